// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: memory-backed responder for the AHB slave user-side interface.
// Accepts sel/addr/write/wdata requests, stretches each access by WAIT_CYCLES
// wait states, and answers with a one-cycle ready pulse, rdata and slave_error.
// Optional feature: define AHB_WSTRB_EN to add the strb port and per-byte writes.

`ifndef AHB_ADDR_WIDTH
`define AHB_ADDR_WIDTH 32
`endif
`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH 32
`endif

module ahb_slave_mem #(
  parameter int unsigned             ADDR_WIDTH  = `AHB_ADDR_WIDTH,
  parameter int unsigned             DATA_WIDTH  = `AHB_DATA_WIDTH,
  parameter int unsigned             DEPTH       = 256,
  parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR   = '0,
  parameter int unsigned             WAIT_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      sel,
  input  logic [ADDR_WIDTH-1:0]     addr,
  input  logic                      write,
  input  logic [DATA_WIDTH-1:0]     wdata,
`ifdef AHB_WSTRB_EN
  input  logic [DATA_WIDTH/8-1:0]   strb,
`endif
  input  logic                      inject_error,
  output logic                      ready,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic                      slave_error
);

  localparam int unsigned STRB_W     = DATA_WIDTH / 8;
  localparam int unsigned BYTE_SHIFT = $clog2(STRB_W);
  localparam int unsigned IDX_W      = $clog2(DEPTH);
  localparam int unsigned CNT_W      = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic                  ready_q, ready_d;
  logic                  slave_error_q, slave_error_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
`ifdef AHB_WSTRB_EN
  logic [STRB_W-1:0]     strb_q, strb_d;
`endif

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] cur_addr_c;
  logic                  cur_write_c;
  logic [ADDR_WIDTH-1:0] offset_c;
  logic                  decode_err_c;
  logic [IDX_W-1:0]      idx_c;
  logic                  go_resp_c;
  logic                  resp_err_c;
  logic                  mem_we_c;

  // Address decode on the request being accepted (IDLE) or the latched one
  always_comb begin
    cur_addr_c   = (state_q == S_IDLE) ? addr  : addr_q;
    cur_write_c  = (state_q == S_IDLE) ? write : write_q;
    offset_c     = cur_addr_c - BASE_ADDR;
    idx_c        = IDX_W'(offset_c >> BYTE_SHIFT);
    decode_err_c = (cur_addr_c < BASE_ADDR)
                 || ((offset_c >> (BYTE_SHIFT + IDX_W)) != '0)
                 || ((cur_addr_c & ADDR_WIDTH'(STRB_W - 1)) != '0);
  end

  // Next-state, request latch and registered response computation
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    write_d       = write_q;
    wdata_d       = wdata_q;
    err_d         = err_q;
    ready_d       = 1'b0;
    slave_error_d = 1'b0;
    rdata_d       = '0;
    go_resp_c     = 1'b0;
`ifdef AHB_WSTRB_EN
    strb_d        = strb_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (sel) begin
          addr_d  = addr;
          write_d = write;
          wdata_d = wdata;
`ifdef AHB_WSTRB_EN
          strb_d  = strb;
`endif
          err_d   = inject_error;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            state_d   = S_RESP;
            go_resp_c = 1'b1;
          end else begin
            state_d   = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        err_d = err_q | inject_error;
        if (!sel) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          err_d   = 1'b0;
        end else if (cnt_q <= CNT_W'(1)) begin
          state_d   = S_RESP;
          cnt_d     = '0;
          go_resp_c = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        err_d   = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        err_d   = 1'b0;
      end
    endcase

    // Response is computed on the edge entering RESP so outputs stay registered
    resp_err_c = decode_err_c | err_q | inject_error;
    if (go_resp_c) begin
      ready_d       = 1'b1;
      slave_error_d = resp_err_c;
      if (!resp_err_c && !cur_write_c) begin
        rdata_d = mem[idx_c];
      end
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      addr_q        <= '0;
      write_q       <= 1'b0;
      wdata_q       <= '0;
      err_q         <= 1'b0;
      ready_q       <= 1'b0;
      slave_error_q <= 1'b0;
      rdata_q       <= '0;
`ifdef AHB_WSTRB_EN
      strb_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      write_q       <= write_d;
      wdata_q       <= wdata_d;
      err_q         <= err_d;
      ready_q       <= ready_d;
      slave_error_q <= slave_error_d;
      rdata_q       <= rdata_d;
`ifdef AHB_WSTRB_EN
      strb_q        <= strb_d;
`endif
    end
  end

  // Write commits at the end of an error-free RESP cycle; reset drops it
  assign mem_we_c = (state_q == S_RESP) && write_q && !slave_error_q;

  // Memory array, intentionally not reset
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
`ifdef AHB_WSTRB_EN
      for (int b = 0; b < STRB_W; b++) begin
        if (strb_q[b]) begin
          mem[idx_c][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
`else
      mem[idx_c] <= wdata_q;
`endif
    end
  end

  assign ready       = ready_q;
  assign rdata       = rdata_q;
  assign slave_error = slave_error_q;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: three instances with WAIT_CYCLES 2, 0 and 5,
// transfer tables with scoreboard-held expectations.
`timescale 1ns/1ps

module tb_ahb_slave_mem;

  localparam int unsigned ND = 3;

  typedef struct {
    int          d;
    logic        wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  st;
    int          inj;
    int          abt;
    bit          eg;
    int          el;
    logic        ee;
    bit          ec;
    logic [31:0] erd;
  } op_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        sel         [ND];
  logic [31:0] addr        [ND];
  logic        write       [ND];
  logic [31:0] wdata       [ND];
`ifdef AHB_WSTRB_EN
  logic [3:0]  strb        [ND];
`endif
  logic        inject      [ND];
  logic        ready       [ND];
  logic [31:0] rdata       [ND];
  logic        slave_error [ND];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  op_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int unsigned W = (g == 0) ? 2 : ((g == 1) ? 0 : 5);
    ahb_slave_mem #(.WAIT_CYCLES(W)) u_dut (
      .clk(clk), .rstn(rstn), .sel(sel[g]), .addr(addr[g]), .write(write[g]),
      .wdata(wdata[g]),
`ifdef AHB_WSTRB_EN
      .strb(strb[g]),
`endif
      .inject_error(inject[g]), .ready(ready[g]), .rdata(rdata[g]),
      .slave_error(slave_error[g])
    );
  end

  function automatic int wc(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 0 : 5);
  endfunction

  function automatic op_t mk(input int d, input logic wr, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] st,
                             input int inj, input int abt, input bit eg,
                             input logic ee, input bit ec, input logic [31:0] erd);
    op_t o;
    o = '{d, wr, a, wd, st, inj, abt, eg, wc(d) + 1, ee, ec, erd};
    return o;
  endfunction

  // Drive one transfer; observe ready latency (in negedges after acceptance)
  task automatic xfer(input op_t o, output bit got, output int lat,
                      output logic err, output logic [31:0] rd, output int t);
    got = 0; lat = 0; err = 1'b0; rd = '0; t = 0;
    @(negedge clk);
    sel[o.d] = 1'b1; write[o.d] = o.wr; addr[o.d] = o.a; wdata[o.d] = o.wd;
`ifdef AHB_WSTRB_EN
    strb[o.d] = o.st;
`endif
    @(posedge clk);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      inject[o.d] = (k == o.inj);
      if (k == o.abt) sel[o.d] = 1'b0;
      if (ready[o.d] === 1'b1) begin
        got = 1; lat = k; err = slave_error[o.d]; rd = rdata[o.d]; t = cyc;
        break;
      end
      if (o.abt > 0 && k >= o.abt + 8) break;
    end
    sel[o.d] = 1'b0;
    inject[o.d] = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      n_checks++;
      if (ready[d] !== 1'b0 || slave_error[d] !== 1'b0 || rdata[d] !== 32'h0) begin
        n_errors++;
        $display("FAIL reset[%0d]: ready=%b err=%b rdata=%h, expected 0/0/0", d, ready[d], slave_error[d], rdata[d]);
      end
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_write_read;
    op_t ops[$]; op_t e; bit got; int lat; logic err; logic [31:0] rd; int t;
    ops.push_back(mk(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 1, 0, 0, 0));
    ops.push_back(mk(0, 0, 32'h10, 32'h0, 4'hF, 0, 0, 1, 0, 1, 32'hDEADBEEF));
    foreach (ops[i]) begin
      sb.push_back(ops[i]);
      xfer(ops[i], got, lat, err, rd, t);
      e = sb.pop_front();
      n_checks++;
      if (got !== e.eg || (e.eg && lat != e.el)) begin n_errors++; $display("FAIL wr_rd[%0d] ready: got=%0b lat=%0d expected got=%0b lat=%0d", i, got, lat, e.eg, e.el); end
      if (e.eg) begin n_checks++; if (err !== e.ee) begin n_errors++; $display("FAIL wr_rd[%0d] slave_error: got=%b expected=%b", i, err, e.ee); end end
      if (e.eg && e.ec) begin n_checks++; if (rd !== e.erd) begin n_errors++; $display("FAIL wr_rd[%0d] rdata: got=%h expected=%h", i, rd, e.erd); end end
    end
    @(negedge clk);
    n_checks++;
    if (ready[0] !== 1'b0 || rdata[0] !== 32'h0) begin
      n_errors++;
      $display("FAIL wr_rd idle_after_resp: ready=%b rdata=%h expected 0/0", ready[0], rdata[0]);
    end
  endtask

  task automatic test_addr_errors;
    op_t ops[$]; op_t e; bit got; int lat; logic err; logic [31:0] rd; int t;
    ops.push_back(mk(0, 1, 32'h0,   32'hCAFEF00D, 4'hF, 0, 0, 1, 0, 0, 0));
    ops.push_back(mk(0, 0, 32'h400, 32'h0,        4'hF, 0, 0, 1, 1, 1, 32'h0));
    ops.push_back(mk(0, 1, 32'h2,   32'hFFFFFFFF, 4'hF, 0, 0, 1, 1, 0, 0));
    ops.push_back(mk(0, 0, 32'h0,   32'h0,        4'hF, 0, 0, 1, 0, 1, 32'hCAFEF00D));
    ops.push_back(mk(0, 1, 32'h3FC, 32'h000003FC, 4'hF, 0, 0, 1, 0, 0, 0));
    ops.push_back(mk(0, 0, 32'h3FC, 32'h0,        4'hF, 0, 0, 1, 0, 1, 32'h000003FC));
    ops.push_back(mk(0, 0, 32'h3,   32'h0,        4'hF, 0, 0, 1, 1, 1, 32'h0));
    foreach (ops[i]) begin
      sb.push_back(ops[i]);
      xfer(ops[i], got, lat, err, rd, t);
      e = sb.pop_front();
      n_checks++;
      if (got !== e.eg || (e.eg && lat != e.el)) begin n_errors++; $display("FAIL addr_err[%0d] ready: got=%0b lat=%0d expected got=%0b lat=%0d", i, got, lat, e.eg, e.el); end
      if (e.eg) begin n_checks++; if (err !== e.ee) begin n_errors++; $display("FAIL addr_err[%0d] slave_error: got=%b expected=%b", i, err, e.ee); end end
      if (e.eg && e.ec) begin n_checks++; if (rd !== e.erd) begin n_errors++; $display("FAIL addr_err[%0d] rdata: got=%h expected=%h", i, rd, e.erd); end end
    end
  endtask

  task automatic test_wait_states;
    op_t ops[$]; op_t e; bit got; int lat; logic err; logic [31:0] rd; int t;
    ops.push_back(mk(1, 1, 32'h20, 32'h0BADF00D, 4'hF, 0, 0, 1, 0, 0, 0));
    ops.push_back(mk(1, 0, 32'h20, 32'h0,        4'hF, 0, 0, 1, 0, 1, 32'h0BADF00D));
    ops.push_back(mk(2, 1, 32'h30, 32'h13579BDF, 4'hF, 0, 0, 1, 0, 0, 0));
    ops.push_back(mk(2, 1, 32'h30, 32'h00000000, 4'hF, 0, 2, 0, 0, 0, 0));
    ops.push_back(mk(2, 0, 32'h30, 32'h0,        4'hF, 0, 0, 1, 0, 1, 32'h13579BDF));
    foreach (ops[i]) begin
      sb.push_back(ops[i]);
      xfer(ops[i], got, lat, err, rd, t);
      e = sb.pop_front();
      n_checks++;
      if (got !== e.eg || (e.eg && lat != e.el)) begin n_errors++; $display("FAIL wait[%0d] ready: got=%0b lat=%0d expected got=%0b lat=%0d", i, got, lat, e.eg, e.el); end
      if (e.eg) begin n_checks++; if (err !== e.ee) begin n_errors++; $display("FAIL wait[%0d] slave_error: got=%b expected=%b", i, err, e.ee); end end
      if (e.eg && e.ec) begin n_checks++; if (rd !== e.erd) begin n_errors++; $display("FAIL wait[%0d] rdata: got=%h expected=%h", i, rd, e.erd); end end
    end
  endtask

  task automatic test_inject;
    op_t ops[$]; op_t e; bit got; int lat; logic err; logic [31:0] rd; int t;
    ops.push_back(mk(0, 1, 32'h8, 32'h12345678, 4'hF, 0, 0, 1, 0, 0, 0));
    ops.push_back(mk(0, 1, 32'h8, 32'h00000055, 4'hF, 1, 0, 1, 1, 0, 0));
    ops.push_back(mk(0, 0, 32'h8, 32'h0,        4'hF, 0, 0, 1, 0, 1, 32'h12345678));
    ops.push_back(mk(0, 0, 32'h8, 32'h0,        4'hF, 2, 0, 1, 1, 1, 32'h0));
    foreach (ops[i]) begin
      sb.push_back(ops[i]);
      xfer(ops[i], got, lat, err, rd, t);
      e = sb.pop_front();
      n_checks++;
      if (got !== e.eg || (e.eg && lat != e.el)) begin n_errors++; $display("FAIL inject[%0d] ready: got=%0b lat=%0d expected got=%0b lat=%0d", i, got, lat, e.eg, e.el); end
      if (e.eg) begin n_checks++; if (err !== e.ee) begin n_errors++; $display("FAIL inject[%0d] slave_error: got=%b expected=%b", i, err, e.ee); end end
      if (e.eg && e.ec) begin n_checks++; if (rd !== e.erd) begin n_errors++; $display("FAIL inject[%0d] rdata: got=%h expected=%h", i, rd, e.erd); end end
    end
  endtask

  task automatic test_back_to_back;
    op_t ops[$]; op_t e; bit got; int lat; logic err; logic [31:0] rd; int t;
    int prev_t;
    for (int i = 0; i < 4; i++)
      ops.push_back(mk(0, 1, 32'h40 + 32'(4*i), 32'hA000_0000 + 32'(i), 4'hF, 0, 0, 1, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      ops.push_back(mk(0, 0, 32'h40 + 32'(4*i), 32'h0, 4'hF, 0, 0, 1, 0, 1, 32'hA000_0000 + 32'(i)));
    prev_t = 0;
    foreach (ops[i]) begin
      sb.push_back(ops[i]);
      xfer(ops[i], got, lat, err, rd, t);
      e = sb.pop_front();
      n_checks++;
      if (got !== e.eg || (e.eg && lat != e.el)) begin n_errors++; $display("FAIL b2b[%0d] ready: got=%0b lat=%0d expected got=%0b lat=%0d", i, got, lat, e.eg, e.el); end
      if (e.eg) begin n_checks++; if (err !== e.ee) begin n_errors++; $display("FAIL b2b[%0d] slave_error: got=%b expected=%b", i, err, e.ee); end end
      if (e.eg && e.ec) begin n_checks++; if (rd !== e.erd) begin n_errors++; $display("FAIL b2b[%0d] rdata: got=%h expected=%h", i, rd, e.erd); end end
      if (i > 0) begin
        n_checks++;
        if (t - prev_t != wc(0) + 2) begin n_errors++; $display("FAIL b2b[%0d] period: got=%0d expected=%0d", i, t - prev_t, wc(0) + 2); end
      end
      prev_t = t;
    end
  endtask

`ifdef AHB_WSTRB_EN
  task automatic test_strobe;
    op_t ops[$]; op_t e; bit got; int lat; logic err; logic [31:0] rd; int t;
    ops.push_back(mk(0, 1, 32'h50, 32'h11223344, 4'hF,    0, 0, 1, 0, 0, 0));
    ops.push_back(mk(0, 1, 32'h50, 32'hAABBCCDD, 4'b0101, 0, 0, 1, 0, 0, 0));
    ops.push_back(mk(0, 0, 32'h50, 32'h0,        4'hF,    0, 0, 1, 0, 1, 32'h11BB33DD));
    ops.push_back(mk(0, 1, 32'h50, 32'hFFFFFFFF, 4'h0,    0, 0, 1, 0, 0, 0));
    ops.push_back(mk(0, 0, 32'h50, 32'h0,        4'hF,    0, 0, 1, 0, 1, 32'h11BB33DD));
    foreach (ops[i]) begin
      sb.push_back(ops[i]);
      xfer(ops[i], got, lat, err, rd, t);
      e = sb.pop_front();
      n_checks++;
      if (got !== e.eg || (e.eg && lat != e.el)) begin n_errors++; $display("FAIL strobe[%0d] ready: got=%0b lat=%0d expected got=%0b lat=%0d", i, got, lat, e.eg, e.el); end
      if (e.eg) begin n_checks++; if (err !== e.ee) begin n_errors++; $display("FAIL strobe[%0d] slave_error: got=%b expected=%b", i, err, e.ee); end end
      if (e.eg && e.ec) begin n_checks++; if (rd !== e.erd) begin n_errors++; $display("FAIL strobe[%0d] rdata: got=%h expected=%h", i, rd, e.erd); end end
    end
  endtask
`endif

  task automatic test_reset_mid;
    op_t o; bit got; int lat; logic err; logic [31:0] rd; int t; bit seen;
    o = mk(0, 1, 32'h60, 32'hA5A5A5A5, 4'hF, 0, 0, 1, 0, 0, 0);
    xfer(o, got, lat, err, rd, t);
    n_checks++;
    if (got !== 1'b1 || err !== 1'b0) begin n_errors++; $display("FAIL rst_mid preload: got=%0b err=%b expected 1/0", got, err); end
    // Reset while in WAIT
    @(negedge clk);
    sel[0] = 1'b1; write[0] = 1'b1; addr[0] = 32'h60; wdata[0] = 32'h5A5A5A5A;
`ifdef AHB_WSTRB_EN
    strb[0] = 4'hF;
`endif
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    n_checks++;
    if (ready[0] !== 1'b0 || slave_error[0] !== 1'b0 || rdata[0] !== 32'h0) begin n_errors++; $display("FAIL rst_mid wait_outputs: ready=%b err=%b rdata=%h expected 0/0/0", ready[0], slave_error[0], rdata[0]); end
    repeat (3) @(negedge clk);
    n_checks++;
    if (ready[0] !== 1'b0) begin n_errors++; $display("FAIL rst_mid held_ready: got=%b expected=0", ready[0]); end
    sel[0] = 1'b0;
    rstn = 1'b1;
    // Reset while ready is high: must clear at once and drop the write
    @(negedge clk);
    sel[0] = 1'b1; write[0] = 1'b1; addr[0] = 32'h60; wdata[0] = 32'h5A5A5A5A;
    @(posedge clk);
    seen = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ready[0] === 1'b1) begin seen = 1; break; end
    end
    n_checks++;
    if (!seen) begin n_errors++; $display("FAIL rst_mid resp_seen: got=0 expected=1"); end
    rstn = 1'b0;
    #1;
    n_checks++;
    if (ready[0] !== 1'b0 || slave_error[0] !== 1'b0) begin n_errors++; $display("FAIL rst_mid resp_outputs: ready=%b err=%b expected 0/0", ready[0], slave_error[0]); end
    @(negedge clk);
    sel[0] = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    // New transfer after release completes; word keeps its pre-reset value
    o = mk(0, 0, 32'h60, 32'h0, 4'hF, 0, 0, 1, 0, 1, 32'hA5A5A5A5);
    sb.push_back(o);
    xfer(o, got, lat, err, rd, t);
    o = sb.pop_front();
    n_checks++;
    if (got !== 1'b1 || lat != o.el || err !== 1'b0 || rd !== o.erd) begin
      n_errors++;
      $display("FAIL rst_mid readback: got=%0b lat=%0d err=%b rdata=%h expected 1/%0d/0/%h", got, lat, err, rd, o.el, o.erd);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < ND; d++) begin
      sel[d] = 1'b0; addr[d] = '0; write[d] = 1'b0; wdata[d] = '0; inject[d] = 1'b0;
`ifdef AHB_WSTRB_EN
      strb[d] = 4'hF;
`endif
    end
    #3;
    test_reset();
    test_write_read();
    test_addr_errors();
    test_wait_states();
    test_inject();
    test_back_to_back();
`ifdef AHB_WSTRB_EN
    test_strobe();
`endif
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
